// File: rtl/sim_status_monitor_if.sv
// Per-hart decode-stage instruction channel watched by sim_status_monitor.
// Hart h occupies inst_i[h*INST_W +: INST_W].
interface sim_status_monitor_if #(
  parameter int unsigned NUM_HART = 1,
  parameter int unsigned INST_W   = 32
);
  logic [NUM_HART-1:0]        inst_vld_i;
  logic [NUM_HART*INST_W-1:0] inst_i;

  modport master (output inst_vld_i, inst_i);
  modport slave  (input  inst_vld_i, inst_i);
endinterface

// File: rtl/sim_status_monitor.sv
// Run controller and pass/fail monitor: stretched core reset, signature
// detection per hart, cycle watchdog and sticky registered verdicts.
module sim_status_monitor #(
  parameter int unsigned       NUM_HART     = 1,
  parameter int unsigned       INST_W       = 32,
  parameter logic [INST_W-1:0] PASS_INST    = 'hc0001073,
  parameter logic [INST_W-1:0] FAIL_INST    = 'h00100073,
  parameter int unsigned       RST_HOLD_CYC = 20,
  parameter int unsigned       TIMEOUT_CYC  = 10000,
  parameter int unsigned       CNT_W        = 32,
  localparam int unsigned      HW           = (NUM_HART > 1) ? $clog2(NUM_HART) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  sim_status_monitor_if.slave   inst_bus,
  output logic                  core_rst_o,
  output logic                  done_o,
  output logic                  pass_o,
  output logic                  fail_o,
  output logic                  timeout_o,
  output logic [NUM_HART-1:0]   pass_mask_o,
  output logic [HW-1:0]         fail_hart_o,
  output logic [CNT_W-1:0]      cycle_cnt_o
);

  localparam int unsigned HOLD_W = (RST_HOLD_CYC > 0) ? $clog2(RST_HOLD_CYC + 1) : 1;

  typedef enum logic [2:0] {
    ST_HOLD,
    ST_RUN,
    ST_PASS,
    ST_FAIL,
    ST_TIMEOUT
  } state_t;

  state_t              state_q;
  logic [HOLD_W-1:0]   hold_q;
  logic                core_rst_q;
  logic                done_q;
  logic                pass_q;
  logic                fail_q;
  logic                timeout_q;
  logic [NUM_HART-1:0] pass_mask_q;
  logic [NUM_HART-1:0] pass_mask_d;
  logic [HW-1:0]       fail_hart_q;
  logic [HW-1:0]       fail_hart_d;
  logic [CNT_W-1:0]    cnt_q;
  logic [CNT_W-1:0]    cnt_d;

  logic [NUM_HART-1:0] pass_hit;
  logic [NUM_HART-1:0] fail_hit;
  logic                fail_any;
  logic                at_limit;

  always_comb begin
    pass_hit    = '0;
    fail_hit    = '0;
    fail_any    = 1'b0;
    fail_hart_d = fail_hart_q;
    for (int unsigned h = 0; h < NUM_HART; h++) begin
      pass_hit[h] = inst_bus.inst_vld_i[h] &&
                    (inst_bus.inst_i[h*INST_W +: INST_W] == PASS_INST);
      fail_hit[h] = inst_bus.inst_vld_i[h] &&
                    (inst_bus.inst_i[h*INST_W +: INST_W] == FAIL_INST);
      if (fail_hit[h] && !fail_any) begin
        fail_any    = 1'b1;
        fail_hart_d = HW'(h);
      end
    end
    pass_mask_d = pass_mask_q | pass_hit;
    // Counter saturates at the watchdog value, so it never wraps.
    at_limit    = (cnt_q == CNT_W'(TIMEOUT_CYC - 1));
    cnt_d       = at_limit ? cnt_q : cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_HOLD;
      hold_q      <= '0;
      core_rst_q  <= 1'b1;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      fail_q      <= 1'b0;
      timeout_q   <= 1'b0;
      pass_mask_q <= '0;
      fail_hart_q <= '0;
      cnt_q       <= '0;
    end else begin
      case (state_q)
        ST_HOLD: begin
          if (hold_q == HOLD_W'(RST_HOLD_CYC)) begin
            state_q    <= ST_RUN;
            core_rst_q <= 1'b0;
          end else begin
            hold_q <= hold_q + HOLD_W'(1);
          end
        end
        ST_RUN: begin
          pass_mask_q <= pass_mask_d;
          cnt_q       <= cnt_d;
          if (fail_any) begin
            state_q     <= ST_FAIL;
            done_q      <= 1'b1;
            fail_q      <= 1'b1;
            fail_hart_q <= fail_hart_d;
          end else if (&pass_mask_d) begin
            state_q <= ST_PASS;
            done_q  <= 1'b1;
            pass_q  <= 1'b1;
          end else if (at_limit) begin
            state_q   <= ST_TIMEOUT;
            done_q    <= 1'b1;
            fail_q    <= 1'b1;
            timeout_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign core_rst_o  = core_rst_q;
  assign done_o      = done_q;
  assign pass_o      = pass_q;
  assign fail_o      = fail_q;
  assign timeout_o   = timeout_q;
  assign pass_mask_o = pass_mask_q;
  assign fail_hart_o = fail_hart_q;
  assign cycle_cnt_o = cnt_q;

endmodule

// File: tb/tb_sim_status_monitor.sv
// Self-checking bench for sim_status_monitor: directed table, corner-case
// sequences and randomized traffic against a cycle-count reference model.
module tb_sim_status_monitor;

  localparam int unsigned NH = 2;
  localparam int unsigned IW = 32;
  localparam int unsigned H  = 4;
  localparam int unsigned T  = 50;
  localparam int unsigned CW = 32;
  localparam logic [31:0] PI = 32'hc0001073;
  localparam logic [31:0] FI = 32'h00100073;

  logic          clk = 1'b0;
  logic          rst;
  logic          core_rst, done, pass, fail, tmo;
  logic [NH-1:0] mask;
  logic [0:0]    fh;
  logic [CW-1:0] cnt;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sim_status_monitor_if #(.NUM_HART(NH), .INST_W(IW)) bus ();

  sim_status_monitor #(
    .NUM_HART(NH), .INST_W(IW), .PASS_INST(PI), .FAIL_INST(FI),
    .RST_HOLD_CYC(H), .TIMEOUT_CYC(T), .CNT_W(CW)
  ) dut (
    .clk_i(clk), .rst_i(rst), .inst_bus(bus),
    .core_rst_o(core_rst), .done_o(done), .pass_o(pass), .fail_o(fail),
    .timeout_o(tmo), .pass_mask_o(mask), .fail_hart_o(fh), .cycle_cnt_o(cnt)
  );

  // Reference model: m_n counts rst-free edges since the last reset; the run
  // phase and the cycle count follow arithmetically from it until a verdict.
  int       m_n;
  bit       m_done, m_pass, m_fail, m_to;
  bit [1:0] m_mask;
  int       m_fh, m_cnt_fz;

  function automatic int exp_cnt();
    if (m_done) return m_cnt_fz;
    return (m_n > int'(H)) ? m_n - int'(H) - 1 : 0;
  endfunction

  function automatic void model_step(input logic r, input logic [1:0] v,
                                     input logic [31:0] a, input logic [31:0] b);
    logic [31:0] ins [2];
    int c, first_fail;
    if (r) begin
      m_n = 0; m_done = 0; m_pass = 0; m_fail = 0; m_to = 0;
      m_mask = 0; m_fh = 0; m_cnt_fz = 0;
      return;
    end
    if (!m_done && m_n > int'(H)) begin
      c = m_n - int'(H) - 1;
      ins[0] = a; ins[1] = b;
      first_fail = -1;
      for (int h = 0; h < 2; h++) begin
        if (v[h] && ins[h] == PI) m_mask[h] = 1'b1;
        if (v[h] && ins[h] == FI && first_fail < 0) first_fail = h;
      end
      if (first_fail >= 0) begin
        m_done = 1; m_fail = 1; m_fh = first_fail;
      end else if (m_mask == 2'b11) begin
        m_done = 1; m_pass = 1;
      end else if (c == int'(T) - 1) begin
        m_done = 1; m_fail = 1; m_to = 1;
      end
      if (m_done) m_cnt_fz = (c == int'(T) - 1) ? c : c + 1;
    end
    m_n++;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    chk("core_rst", 64'(core_rst), 64'(m_n <= int'(H)));
    chk("done", 64'(done), 64'(m_done));
    chk("pass", 64'(pass), 64'(m_pass));
    chk("fail", 64'(fail), 64'(m_fail));
    chk("timeout", 64'(tmo), 64'(m_to));
    chk("pass_mask", 64'(mask), 64'(m_mask));
    chk("fail_hart", 64'(fh), 64'(m_fh));
    chk("cycle_cnt", 64'(cnt), 64'(exp_cnt()));
  endtask

  task automatic cyc(input logic r, input logic [1:0] v,
                     input logic [31:0] a, input logic [31:0] b);
    rst = r;
    bus.inst_vld_i = v;
    bus.inst_i = {b, a};
    @(posedge clk);
    model_step(r, v, a, b);
    #1;
    check_model();
  endtask

  task automatic do_reset();
    cyc(1'b1, 2'b00, '0, '0);
    cyc(1'b1, 2'b00, '0, '0);
    for (int i = 0; i <= int'(H); i++) cyc(1'b0, 2'b00, '0, '0);
  endtask

  task automatic run_to(input int target);
    int guard = 0;
    while (exp_cnt() < target && !m_done && guard < 200) begin
      cyc(1'b0, 2'b00, '0, '0);
      guard++;
    end
    if (exp_cnt() != target) begin
      checks++;
      failures++;
      $display("FAIL run_to: count %0d expected %0d", exp_cnt(), target);
    end
  endtask

  typedef struct {
    logic        r;
    logic [1:0]  v;
    logic [31:0] a;
    logic [31:0] b;
    logic        e_core;
    logic        e_done;
    logic [31:0] e_cnt;
  } vec_t;

  vec_t tbl [9];

  initial begin
    int guard;
    int pass_pct, fail_pct;
    logic [1:0]  rv;
    logic [31:0] ri [2];
    logic        rr;

    rst = 1'b1;
    bus.inst_vld_i = '0;
    bus.inst_i = '0;

    // Reset stretch: 3 reset cycles, 4 held cycles, RUN entry, first count
    tbl[0] = '{1'b1, 2'b00, 32'h0, 32'h0, 1'b1, 1'b0, 32'd0};
    tbl[1] = '{1'b1, 2'b11, PI,    FI,    1'b1, 1'b0, 32'd0};
    tbl[2] = '{1'b1, 2'b00, 32'h0, 32'h0, 1'b1, 1'b0, 32'd0};
    tbl[3] = '{1'b0, 2'b11, FI,    FI,    1'b1, 1'b0, 32'd0};
    tbl[4] = '{1'b0, 2'b00, 32'h0, 32'h0, 1'b1, 1'b0, 32'd0};
    tbl[5] = '{1'b0, 2'b11, PI,    PI,    1'b1, 1'b0, 32'd0};
    tbl[6] = '{1'b0, 2'b00, 32'h0, 32'h0, 1'b1, 1'b0, 32'd0};
    tbl[7] = '{1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 32'd0};
    tbl[8] = '{1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 32'd1};

    for (int i = 0; i < 9; i++) begin
      cyc(tbl[i].r, tbl[i].v, tbl[i].a, tbl[i].b);
      chk("tbl_core_rst", 64'(core_rst), 64'(tbl[i].e_core));
      chk("tbl_done", 64'(done), 64'(tbl[i].e_done));
      chk("tbl_cnt", 64'(cnt), 64'(tbl[i].e_cnt));
      chk("tbl_mask", 64'(mask), 64'd0);
    end

    // Pass: hart0 at cnt 10, hart1 at cnt 20
    run_to(10);
    cyc(1'b0, 2'b01, PI, '0);
    chk("pass_mask01", 64'(mask), 64'd1);
    chk("pass_not_yet", 64'(pass), 64'd0);
    run_to(20);
    cyc(1'b0, 2'b10, '0, PI);
    chk("pass_pass", 64'(pass), 64'd1);
    chk("pass_done", 64'(done), 64'd1);
    chk("pass_cnt", 64'(cnt), 64'd21);
    for (int i = 0; i < 3; i++) cyc(1'b0, 2'b11, FI, FI);
    chk("pass_frozen_cnt", 64'(cnt), 64'd21);
    chk("pass_not_overturned", 64'(fail), 64'd0);

    // Fail priority over a simultaneous pass completion
    do_reset();
    run_to(5);
    cyc(1'b0, 2'b10, '0, PI);
    cyc(1'b0, 2'b11, PI, FI);
    chk("prio_fail", 64'(fail), 64'd1);
    chk("prio_pass", 64'(pass), 64'd0);
    chk("prio_hart", 64'(fh), 64'd1);
    cyc(1'b0, 2'b01, PI, '0);
    chk("prio_sticky_pass", 64'(pass), 64'd0);
    chk("prio_sticky_fail", 64'(fail), 64'd1);

    // Timeout, no signatures
    do_reset();
    guard = 0;
    while (!m_done && guard < 100) begin
      cyc(1'b0, 2'b00, '0, '0);
      guard++;
    end
    chk("to_timeout", 64'(tmo), 64'd1);
    chk("to_fail", 64'(fail), 64'd1);
    chk("to_done", 64'(done), 64'd1);
    chk("to_cnt", 64'(cnt), 64'd49);
    cyc(1'b0, 2'b00, '0, '0);
    chk("to_cnt_frozen", 64'(cnt), 64'd49);

    // Final pass hit on the watchdog cycle
    do_reset();
    cyc(1'b0, 2'b01, PI, '0);
    run_to(49);
    cyc(1'b0, 2'b10, '0, PI);
    chk("to2_pass", 64'(pass), 64'd1);
    chk("to2_timeout", 64'(tmo), 64'd0);
    chk("to2_cnt", 64'(cnt), 64'd49);

    // Valid gating and mid-run reset pulse
    do_reset();
    cyc(1'b0, 2'b00, PI, PI);
    chk("gate_mask", 64'(mask), 64'd0);
    cyc(1'b0, 2'b10, FI, FI);
    chk("gate_fail", 64'(fail), 64'd1);
    chk("gate_hart", 64'(fh), 64'd1);
    do_reset();
    cyc(1'b0, 2'b01, PI, '0);
    run_to(30);
    cyc(1'b1, 2'b00, '0, '0);
    chk("mrst_core", 64'(core_rst), 64'd1);
    chk("mrst_mask", 64'(mask), 64'd0);
    chk("mrst_cnt", 64'(cnt), 64'd0);
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 2'b00, '0, '0);
      chk("mrst_hold", 64'(core_rst), 64'd1);
    end
    cyc(1'b0, 2'b00, '0, '0);
    chk("mrst_run_core", 64'(core_rst), 64'd0);
    chk("mrst_run_cnt", 64'(cnt), 64'd0);

    // Randomized traffic; each reset picks new signature densities
    pass_pct = 5;
    fail_pct = 1;
    for (int n = 0; n < 4000; n++) begin
      rr = ($urandom_range(0, 99) < (m_done ? 15 : 1));
      rv = 2'($urandom);
      for (int h = 0; h < 2; h++) begin
        int p;
        p = int'($urandom_range(0, 99));
        if (p < pass_pct) ri[h] = PI;
        else if (p < pass_pct + fail_pct) ri[h] = FI;
        else ri[h] = $urandom;
      end
      cyc(rr, rv, ri[0], ri[1]);
      if (rr) begin
        pass_pct = int'($urandom_range(0, 6));
        fail_pct = int'($urandom_range(0, 2));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
